// File: rtl/serial_byte_proc_pkg.sv
// Shared constants, FSM encoding and the byte transform for serial_byte_proc.
package serial_proc_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_ADD  = 2'd1;
  localparam logic [1:0] MODE_INV  = 2'd2;
  localparam logic [1:0] MODE_XOR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } tx_state_e;

  // Byte transform applied at FIFO write time.
  function automatic logic [BYTE_W-1:0] byte_xform(
    input logic [1:0]        mode,
    input logic [BYTE_W-1:0] b,
    input logic [BYTE_W-1:0] add,
    input logic [BYTE_W-1:0] key
  );
    case (mode)
      MODE_ADD: byte_xform = BYTE_W'(b + add);
      MODE_INV: byte_xform = ~b;
      MODE_XOR: byte_xform = b ^ key;
      default:  byte_xform = b;
    endcase
  endfunction

endpackage

// File: rtl/serial_byte_proc_if.sv
// Receiver/transmitter handshake bundle.
//   rx_byte/rbyte_ready : byte strobe from the serial receiver
//   tx_sbyte/tx_send    : byte and send strobe to the transmitter
//   tx_busy             : transmitter busy
interface serial_byte_proc_if;
  import serial_proc_pkg::*;

  logic [BYTE_W-1:0] rx_byte;
  logic              rbyte_ready;
  logic [BYTE_W-1:0] tx_sbyte;
  logic              tx_send;
  logic              tx_busy;

  modport master (output rx_byte, output rbyte_ready, output tx_busy,
                  input  tx_sbyte, input tx_send);
  modport slave  (input  rx_byte, input rbyte_ready, input tx_busy,
                  output tx_sbyte, output tx_send);
endinterface

// File: rtl/serial_byte_proc_sync_fifo.sv
// Synchronous FIFO with registered read data.
//   push_i/din_i  : write request and data
//   pop_i/dout_o  : read request; dout_o updates on the edge after a pop
//   full_o/empty_o/level_o : occupancy status
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] dout_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Storage; not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= din_i;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      dout_q  <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok) begin
        rd_q   <= rd_q + AW'(1);
        dout_q <= mem[rd_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout_o  = dout_q;
  assign level_o = level_q;
endmodule

// File: rtl/serial_byte_proc.sv
// Buffered serial echo path: transforms received bytes, queues them, paces
// transmission on tx_busy, and drives a byte-selected LED blink window.
//   clk100/reset_n : clock, async active-low reset
//   bus            : rx strobe in, tx byte/send out, tx_busy in
//   mode           : transform select, sampled at write
//   cnt_clr_n/cnt_run : blink counter clear / enable
//   led, fifo_level, ovf_cnt : status outputs
module serial_byte_proc
  import serial_proc_pkg::*;
#(
  parameter int unsigned      DEPTH      = 16,
  parameter logic [BYTE_W-1:0] ADD_VAL   = 8'd1,
  parameter logic [BYTE_W-1:0] XOR_KEY   = 8'h55,
  parameter int unsigned      CNT_W      = 32,
  parameter int unsigned      LED_W      = 4,
  parameter int unsigned      SPEED_BITS = 2,
  parameter int unsigned      LED_TOP    = 27
) (
  input  logic                   clk100,
  input  logic                   reset_n,
  serial_byte_proc_if.slave      bus,
  input  logic [1:0]             mode,
  input  logic                   cnt_clr_n,
  input  logic                   cnt_run,
  output logic [LED_W-1:0]       led,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             ovf_cnt
);
  localparam int unsigned LED_LSB_TOP = LED_TOP - LED_W + 1;

  logic [1:0]            rst_sync_q;
  logic                  rst_n_int;
  tx_state_e             state_q;
  logic                  tx_send_q;
  logic [SPEED_BITS-1:0] speed_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            ovf_q;
  logic                  fifo_full, fifo_empty;
  logic                  pop_c, push_c, drop_c;
  logic [BYTE_W-1:0]     wr_byte_c, head_byte;

  // Reset asserts asynchronously, releases two edges later.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  assign pop_c     = (state_q == ST_IDLE) && !fifo_empty && !bus.tx_busy;
  assign push_c    = bus.rbyte_ready && (!fifo_full || pop_c);
  assign drop_c    = bus.rbyte_ready && fifo_full && !pop_c;
  assign wr_byte_c = byte_xform(mode, bus.rx_byte, ADD_VAL, XOR_KEY);

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
    .clk     (clk100),
    .rst_n   (rst_n_int),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .din_i   (wr_byte_c),
    .dout_o  (head_byte),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Tx pacing FSM; GUARD absorbs the transmitter's busy-rise latency.
  always_ff @(posedge clk100 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= ST_IDLE;
      tx_send_q <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (pop_c) begin
          state_q   <= ST_SEND;
          tx_send_q <= 1'b1;
        end
        ST_SEND:  state_q <= ST_GUARD;
        ST_GUARD: state_q <= ST_WAIT;
        ST_WAIT:  if (!bus.tx_busy) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Speed select (raw byte, also on drops), overflow count and blink counter.
  always_ff @(posedge clk100 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      speed_q <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (bus.rbyte_ready) speed_q <= bus.rx_byte[SPEED_BITS-1:0];
      if (drop_c && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
      if (!cnt_clr_n)   cnt_q <= '0;
      else if (cnt_run) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Window slides toward the LSBs as speed grows.
  assign led = LED_W'(cnt_q >> (LED_LSB_TOP - 32'(speed_q)));

  assign bus.tx_sbyte = head_byte;
  assign bus.tx_send  = tx_send_q;
  assign ovf_cnt      = ovf_q;
endmodule

// File: tb/tb_serial_byte_proc.sv
// Scoreboard bench for serial_byte_proc.
module tb_serial_byte_proc;
  logic       clk100 = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic       cnt_clr_n, cnt_run;
  logic [3:0] led;
  logic [4:0] fifo_level;
  logic [7:0] ovf_cnt;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_strobes = 0;
  logic [7:0] exp_q [$];

  serial_byte_proc_if bus();

  serial_byte_proc dut (
    .clk100     (clk100),
    .reset_n    (reset_n),
    .bus        (bus),
    .mode       (mode),
    .cnt_clr_n  (cnt_clr_n),
    .cnt_run    (cnt_run),
    .led        (led),
    .fifo_level (fifo_level),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_xform(input logic [1:0] m, input logic [7:0] b);
    logic [8:0] s;
    case (m)
      2'd1: begin s = {1'b0, b} + 9'd1; model_xform = s[7:0]; end
      2'd2: model_xform = b ^ 8'hFF;
      2'd3: model_xform = b ^ 8'h55;
      default: model_xform = b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk100); #1;
  endtask

  // One rbyte_ready strobe; expected output queued when the byte is accepted.
  task automatic rx(input logic [7:0] b, input bit acc);
    bus.rx_byte     = b;
    bus.rbyte_ready = 1'b1;
    if (acc) exp_q.push_back(model_xform(mode, b));
    tick();
    bus.rbyte_ready = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || fifo_level != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 0);
    repeat (4) tick();
  endtask

  // Transmit monitor: every strobe must match the queue head.
  always @(negedge clk100) begin
    if (reset_n && bus.tx_send) begin
      n_strobes++;
      if (exp_q.size() == 0) check("unexp_send", 32'(bus.tx_send), 0);
      else check("tx_byte", 32'(bus.tx_sbyte), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int s0;
    reset_n = 1'b0; mode = 2'd0; cnt_clr_n = 1'b1; cnt_run = 1'b0;
    bus.rx_byte = 8'h00; bus.rbyte_ready = 1'b0; bus.tx_busy = 1'b0;
    repeat (3) tick();
    check("rst_level", 32'(fifo_level), 0);
    check("rst_send", 32'(bus.tx_send), 0);
    check("rst_sbyte", 32'(bus.tx_sbyte), 0);
    check("rst_ovf", 32'(ovf_cnt), 0);
    check("rst_led", 32'(led), 0);
    reset_n = 1'b1;
    repeat (5) tick();

    // ADD echo and latency
    mode = 2'd1;
    rx(8'h41, 1);
    check("lat_n1_send", 32'(bus.tx_send), 0);
    tick();
    check("lat_n2_send", 32'(bus.tx_send), 1);
    check("lat_n2_byte", 32'(bus.tx_sbyte), 32'h42);
    wait_drain();
    rx(8'hFF, 1);
    wait_drain();

    // INV, XOR, and mode change after queueing
    mode = 2'd2; rx(8'h0F, 1); wait_drain();
    mode = 2'd3; rx(8'hAA, 1); wait_drain();
    bus.tx_busy = 1'b1;
    rx(8'h01, 1); rx(8'h02, 1);
    mode = 2'd0;
    tick();
    bus.tx_busy = 1'b0;
    wait_drain();

    // Burst into a blocked transmitter
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) rx(8'(8'h10 + i), i < 16);
    check("burst_level", 32'(fifo_level), 16);
    check("burst_ovf", 32'(ovf_cnt), 4);

    // Full FIFO, push coincides with an IDLE pop
    bus.tx_busy = 1'b0;
    rx(8'hA5, 1);
    bus.tx_busy = 1'b1;
    repeat (3) tick();
    check("fullpop_level", 32'(fifo_level), 16);
    check("fullpop_ovf", 32'(ovf_cnt), 4);

    for (int i = 0; i < 300; i++) rx(8'(i), 0);
    check("ovf_sat", 32'(ovf_cnt), 255);

    s0 = n_strobes;
    bus.tx_busy = 1'b0;
    wait_drain();
    check("burst_strobes", 32'(n_strobes - s0), 16);
    check("burst_empty", 32'(fifo_level), 0);

    // Blink window select
    cnt_run = 1'b1;
    force dut.cnt_q = 32'h0F00_0000;
    rx(8'h00, 1); check("led_sp0", 32'(led), 32'hF);
    rx(8'h01, 1); check("led_sp1", 32'(led), 32'hE);
    rx(8'h02, 1); check("led_sp2", 32'(led), 32'hC);
    rx(8'h03, 1); check("led_sp3", 32'(led), 32'h8);
    release dut.cnt_q;
    cnt_clr_n = 1'b0;
    tick();
    check("led_clr", 32'(led), 0);
    cnt_clr_n = 1'b1; cnt_run = 1'b0;
    wait_drain();

    // Reset during SEND with bytes queued
    bus.tx_busy = 1'b1;
    rx(8'h61, 1); rx(8'h62, 1); rx(8'h63, 1);
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_send) break;
    end
    check("mid_send_seen", 32'(bus.tx_send), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_send", 32'(bus.tx_send), 0);
    exp_q.delete();
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_ovf", 32'(ovf_cnt), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    s0 = n_strobes;
    repeat (12) tick();
    check("post_rst_quiet", 32'(n_strobes - s0), 0);
    check("post_rst_level", 32'(fifo_level), 0);
    rx(8'h5A, 1);
    wait_drain();
    check("post_rst_strobe", 32'(n_strobes - s0), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
